// File: rtl/prog_loader_pkg.sv
// Shared command codes, FSM encoding and small decode helpers for the program loader.
package prog_loader_pkg;

    localparam logic [7:0] LDR_CMD_IMEM = 8'hA5;
    localparam logic [7:0] LDR_CMD_DMEM = 8'h5A;
    localparam logic [7:0] LDR_CMD_RUN  = 8'hC3;
    localparam logic [7:0] LDR_CMD_HALT = 8'h3C;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CNT_LO  = 3'd1,
        ST_CNT_HI  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_RUN_REL = 3'd5,
        ST_RUN     = 3'd6
    } ldr_state_t;

    function automatic logic is_load_cmd(input logic [7:0] b);
        return (b == LDR_CMD_IMEM) || (b == LDR_CMD_DMEM);
    endfunction

    function automatic logic is_frame_state(input ldr_state_t s);
        case (s)
            ST_CNT_LO, ST_CNT_HI, ST_PAYLOAD, ST_CHECK: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/prog_loader_word_asm.sv
// Byte-to-word assembler: little-endian shift register, byte counter and running XOR.
module ldr_word_asm
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  dat,
    output logic [31:0] word,
    output logic        done,
    output logic [7:0]  xsum
);

    logic [23:0] shift_r;
    logic [1:0]  bcnt_r;
    logic [7:0]  xsum_r;

    // Shift bytes in from the top so the first byte ends up in bits 7:0.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= 24'd0;
            bcnt_r  <= 2'd0;
            xsum_r  <= 8'd0;
        end else if (clr) begin
            shift_r <= 24'd0;
            bcnt_r  <= 2'd0;
            xsum_r  <= 8'd0;
        end else if (en) begin
            shift_r <= {dat, shift_r[23:8]};
            bcnt_r  <= bcnt_r + 2'd1;
            xsum_r  <= xsum_r ^ dat;
        end else begin
            shift_r <= shift_r;
            bcnt_r  <= bcnt_r;
            xsum_r  <= xsum_r;
        end
    end

    assign word = {dat, shift_r};
    assign done = en && (bcnt_r == 2'd3);
    assign xsum = xsum_r;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing 32-bit words into instruction/data BRAM and
// gating the CPU reset/stall until a run command arrives.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_dat,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] i_w_addr,
    output logic [DATA_W-1:0] i_w_dat,
    output logic              i_w_enb,
    output logic [3:0]        i_w_byte_enb,
    output logic [ADDR_W-1:0] d_w_addr,
    output logic [DATA_W-1:0] d_w_dat,
    output logic              d_w_enb,
    output logic [3:0]        d_w_byte_enb,
    output logic              cpu_rst,
    output logic              pc_stall,
    output logic              load_err,
    output logic              busy
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [16:0] DEPTH_V = 17'(DEPTH);

    ldr_state_t  state_r, state_nxt_s;
    logic        acc_s, start_s, lo_s, hi_s, pay_en_s, set_err_s, clr_err_s;
    logic        done_s, last_word_s, tgt_dmem_r;
    logic [7:0]  cnt_lo_r, xsum_s;
    logic [15:0] cnt_s, cnt_r, word_idx_r;
    logic [31:0] word_s;

    assign in_ready    = ~rst;
    assign acc_s       = in_valid && in_ready;
    assign pay_en_s    = acc_s && (state_r == ST_PAYLOAD);
    assign cnt_s       = {in_dat, cnt_lo_r};
    assign last_word_s = (word_idx_r == (cnt_r - 16'd1));

    ldr_word_asm u_asm (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_s),
        .en   (pay_en_s),
        .dat  (in_dat),
        .word (word_s),
        .done (done_s),
        .xsum (xsum_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-byte control strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        lo_s        = 1'b0;
        hi_s        = 1'b0;
        set_err_s   = 1'b0;
        clr_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (acc_s && is_load_cmd(in_dat)) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_CNT_LO;
                end else if (acc_s && (in_dat == LDR_CMD_RUN)) begin
                    state_nxt_s = ST_RUN_REL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CNT_LO: begin
                if (acc_s) begin
                    lo_s        = 1'b1;
                    state_nxt_s = ST_CNT_HI;
                end else begin
                    state_nxt_s = ST_CNT_LO;
                end
            end
            ST_CNT_HI: begin
                if (acc_s) begin
                    hi_s = 1'b1;
                    if ({1'b0, cnt_s} > DEPTH_V) begin
                        set_err_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (cnt_s == 16'd0) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_PAYLOAD;
                    end
                end else begin
                    state_nxt_s = ST_CNT_HI;
                end
            end
            ST_PAYLOAD: begin
                if (done_s && last_word_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
                if (acc_s) begin
                    if (in_dat == xsum_s) begin
                        clr_err_s = 1'b1;
                    end else begin
                        set_err_s = 1'b1;
                    end
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            ST_RUN_REL: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (acc_s && (in_dat == LDR_CMD_HALT)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: count/index tracking, one-cycle BRAM write pulses, error and CPU control.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_dmem_r   <= 1'b0;
            cnt_lo_r     <= 8'd0;
            cnt_r        <= 16'd0;
            word_idx_r   <= 16'd0;
            i_w_addr     <= '0;
            i_w_dat      <= '0;
            i_w_enb      <= 1'b0;
            i_w_byte_enb <= 4'd0;
            d_w_addr     <= '0;
            d_w_dat      <= '0;
            d_w_enb      <= 1'b0;
            d_w_byte_enb <= 4'd0;
            load_err     <= 1'b0;
            cpu_rst      <= 1'b1;
            pc_stall     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            i_w_enb      <= 1'b0;
            i_w_byte_enb <= 4'd0;
            d_w_enb      <= 1'b0;
            d_w_byte_enb <= 4'd0;
            if (start_s) begin
                tgt_dmem_r <= (in_dat == LDR_CMD_DMEM);
                word_idx_r <= 16'd0;
            end
            if (lo_s) begin
                cnt_lo_r <= in_dat;
            end
            if (hi_s) begin
                cnt_r <= cnt_s;
            end
            if (done_s) begin
                word_idx_r <= word_idx_r + 16'd1;
                if (tgt_dmem_r) begin
                    d_w_enb      <= 1'b1;
                    d_w_byte_enb <= 4'hF;
                    d_w_addr     <= word_idx_r[ADDR_W-1:0];
                    d_w_dat      <= word_s;
                end else begin
                    i_w_enb      <= 1'b1;
                    i_w_byte_enb <= 4'hF;
                    i_w_addr     <= word_idx_r[ADDR_W-1:0];
                    i_w_dat      <= word_s;
                end
            end
            if (set_err_s) begin
                load_err <= 1'b1;
            end else if (clr_err_s) begin
                load_err <= 1'b0;
            end
            // Decoded from the next state so these track the state register exactly.
            cpu_rst  <= !((state_nxt_s == ST_RUN_REL) || (state_nxt_s == ST_RUN));
            pc_stall <= (state_nxt_s != ST_RUN);
            busy     <= is_frame_state(state_nxt_s);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed + randomized bench for prog_loader; expected BRAM contents and flags come
// from a frame-level model (byte lists, XOR sums, shadow memories).
module tb_prog_loader;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_dat = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [ADDR_W-1:0] i_w_addr, d_w_addr;
    logic [31:0] i_w_dat, d_w_dat;
    logic        i_w_enb, d_w_enb;
    logic [3:0]  i_w_byte_enb, d_w_byte_enb;
    logic        cpu_rst, pc_stall, load_err, busy;

    int checks = 0;
    int failures = 0;
    int i_pulses = 0;
    int d_pulses = 0;
    bit err_model = 1'b0;
    logic [31:0] i_shadow [0:DEPTH-1];
    logic [31:0] d_shadow [0:DEPTH-1];
    logic [31:0] i_model [int];
    logic [31:0] d_model [int];
    logic [31:0] wq [$];

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_dat       (in_dat),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .i_w_addr     (i_w_addr),
        .i_w_dat      (i_w_dat),
        .i_w_enb      (i_w_enb),
        .i_w_byte_enb (i_w_byte_enb),
        .d_w_addr     (d_w_addr),
        .d_w_dat      (d_w_dat),
        .d_w_enb      (d_w_enb),
        .d_w_byte_enb (d_w_byte_enb),
        .cpu_rst      (cpu_rst),
        .pc_stall     (pc_stall),
        .load_err     (load_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Shadow BRAMs fed only by the DUT write ports.
    always @(posedge clk) begin
        if (i_w_enb) begin
            i_shadow[i_w_addr] <= i_w_dat;
            i_pulses <= i_pulses + 1;
        end
        if (d_w_enb) begin
            d_shadow[d_w_addr] <= d_w_dat;
            d_pulses <= d_pulses + 1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        in_dat   = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int gap_for(input int mode, input int n);
        case (mode)
            1:       return ((n % 3) == 0) ? 3 : 0;
            2:       return int'($urandom_range(0, 3));
            default: return 0;
        endcase
    endfunction

    // Sends one load frame of the words in wq and checks every write as it happens.
    task automatic load_frame(input bit dmem, input bit bad, input int mode);
        logic [7:0]  x, b;
        logic [31:0] w;
        logic [15:0] n16;
        int n, ip0, dp0, nb;
        n = wq.size();
        n16 = 16'(n);
        x = 8'd0;
        nb = 0;
        ip0 = i_pulses;
        dp0 = d_pulses;
        put(dmem ? 8'h5A : 8'hA5, gap_for(mode, nb++));
        chk("busy_after_cmd", 32'(busy), 32'd1);
        put(n16[7:0], gap_for(mode, nb++));
        put(n16[15:8], gap_for(mode, nb++));
        for (int wi = 0; wi < n; wi++) begin
            w = wq[wi];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                x = x ^ b;
                put(b, gap_for(mode, nb++));
                if (k == 3) begin
                    chk("wr_enb", 32'(dmem ? d_w_enb : i_w_enb), 32'd1);
                    chk("wr_other_idle", 32'(dmem ? i_w_enb : d_w_enb), 32'd0);
                    chk("wr_addr", 32'(dmem ? d_w_addr : i_w_addr), 32'(wi));
                    chk("wr_dat", dmem ? d_w_dat : i_w_dat, w);
                    chk("wr_be", 32'(dmem ? d_w_byte_enb : i_w_byte_enb), 32'hF);
                end else begin
                    chk("no_wr_mid_word", 32'(i_w_enb | d_w_enb), 32'd0);
                end
                if (dmem) d_model[wi] = w;
                else      i_model[wi] = w;
            end
        end
        put(bad ? (x ^ 8'h08) : x, gap_for(mode, nb++));
        err_model = bad;
        chk("load_err", 32'(load_err), 32'(err_model));
        chk("busy_after_chk", 32'(busy), 32'd0);
        chk("cpu_held", 32'({cpu_rst, pc_stall}), 32'd3);
        chk("tgt_pulse_count", 32'(dmem ? d_pulses - dp0 : i_pulses - ip0), 32'(n));
        chk("other_pulse_count", 32'(dmem ? i_pulses - ip0 : d_pulses - dp0), 32'd0);
    endtask

    task automatic fill(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    initial begin
        int ip0, dp0;
        logic [31:0] w;

        // Reset values, sampled while rst is still high
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_cpu", 32'({cpu_rst, pc_stall}), 32'd3);
        chk("rst_err_busy", 32'({load_err, busy}), 32'd0);
        chk("rst_enb", 32'({i_w_enb, d_w_enb}), 32'd0);
        chk("rst_iaddr", 32'(i_w_addr), 32'd0);
        chk("rst_ddat", d_w_dat, 32'd0);
        rst = 1'b0;
        tick();
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // IMEM directed program load
        wq.delete();
        wq.push_back(32'h00500013);
        wq.push_back(32'h00A00293);
        load_frame(1'b0, 1'b0, 0);

        // Bad checksum on one data word, then a good frame clears the flag
        wq.delete();
        wq.push_back(32'h00000008);
        load_frame(1'b1, 1'b1, 0);
        chk("dmem0_written", d_shadow[0], 32'h00000008);
        fill(1);
        load_frame(1'b1, 1'b0, 0);

        // Oversize count DEPTH+1
        ip0 = i_pulses;
        dp0 = d_pulses;
        put(8'h5A, 0);
        put(8'h01, 0);
        put(8'h10, 0);
        err_model = 1'b1;
        chk("oversize_err", 32'(load_err), 32'(err_model));
        chk("oversize_idle", 32'(busy), 32'd0);
        put(8'h11, 0);
        put(8'h22, 0);
        chk("oversize_no_writes", 32'((i_pulses - ip0) + (d_pulses - dp0)), 32'd0);
        chk("oversize_still_idle", 32'(busy), 32'd0);

        // Run / halt sequencing with ignored bytes
        put(8'h77, 0);
        chk("garbage_idle", 32'({busy, cpu_rst, pc_stall}), 32'b011);
        put(8'h3C, 0);
        chk("halt_in_idle", 32'({busy, cpu_rst, pc_stall}), 32'b011);
        put(8'hC3, 0);
        chk("run_rel", 32'({cpu_rst, pc_stall}), 32'b01);
        tick();
        chk("run", 32'({cpu_rst, pc_stall}), 32'b00);
        put(8'h77, 2);
        put(8'hA5, 0);
        chk("run_ignores", 32'({busy, cpu_rst, pc_stall}), 32'b000);
        put(8'h3C, 1);
        chk("halt", 32'({cpu_rst, pc_stall}), 32'b11);

        // Gapped 3-word load
        fill(3);
        load_frame(1'b0, 1'b0, 1);

        // Randomized frames, including empty ones
        repeat (8) begin
            fill(int'($urandom_range(0, 5)));
            load_frame(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 2);
        end

        // Reset arriving with the 4th byte of a word
        ip0 = i_pulses;
        w = $urandom;
        put(8'hA5, 0);
        put(8'h01, 0);
        put(8'h00, 0);
        put(w[7:0], 0);
        put(w[15:8], 0);
        put(w[23:16], 0);
        in_dat = w[31:24];
        in_valid = 1'b1;
        rst = 1'b1;
        tick();
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_enb", 32'({i_w_enb, d_w_enb}), 32'd0);
        chk("midrst_state", 32'({busy, cpu_rst, pc_stall, load_err}), 32'b0110);
        rst = 1'b0;
        in_valid = 1'b0;
        err_model = 1'b0;
        tick();
        chk("midrst_no_pulse", 32'(i_pulses - ip0), 32'd0);
        fill(2);
        load_frame(1'b0, 1'b0, 0);

        // Full-depth data load; last write lands at DEPTH-1
        fill(DEPTH);
        load_frame(1'b1, 1'b0, 0);
        chk("depth_last_addr", 32'(d_w_addr), 32'(DEPTH - 1));

        foreach (i_model[a]) chk("imem_contents", i_shadow[a], i_model[a]);
        foreach (d_model[a]) chk("dmem_contents", d_shadow[a], d_model[a]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader that sits directly upstream of the instruction and data bram32 instances and the riscv_cpu.
- Receives a framed byte stream (e.g. from a UART RX) and writes 32-bit words into instruction or data BRAM.
- Holds the CPU in reset/stall while loading, then releases it on command.
- Replaces the simulation-only $readmemh preload with a synthesizable path.

Parameters:
- ADDR_W, `RAM_ADDR_WIDTH (12): BRAM word-address width.
- DATA_W, `DATA_WIDTH (32): BRAM word width; fixed at 32, 4 bytes per word.
- DEPTH, 2**ADDR_W: maximum words per load.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_dat  in  8  received byte
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- i_w_addr  out  ADDR_W  instruction BRAM word address
- i_w_dat  out  32  instruction BRAM write data
- i_w_enb  out  1  instruction BRAM write enable, one-cycle pulse
- i_w_byte_enb  out  4  instruction BRAM byte enables
- d_w_addr  out  ADDR_W  data BRAM word address
- d_w_dat  out  32  data BRAM write data
- d_w_enb  out  1  data BRAM write enable, one-cycle pulse
- d_w_byte_enb  out  4  data BRAM byte enables
- cpu_rst  out  1  drives riscv_cpu rst
- pc_stall  out  1  drives riscv_cpu pc_stall
- load_err  out  1  sticky error flag
- busy  out  1  high while a frame is in progress (states CNT_LO through CHECK)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; all *_w_addr, *_w_dat, *_w_enb and *_w_byte_enb = 0; cpu_rst=1; pc_stall=1; load_err=0; busy=0; in_ready=0 during the reset cycle, 1 otherwise.
- in_ready is 1 in every state; a BRAM write never back-pressures the stream.
- Frame format: CMD, CNT_LO, CNT_HI, CNT words of 4 bytes each (little-endian, byte0 = bits 7:0), then CHK.
  - CHK is the XOR of all payload bytes.
  - CMD codes: 0xA5 loads instruction BRAM, 0x5A loads data BRAM, 0xC3 runs, 0x3C halts.
- States: IDLE, CNT_LO, CNT_HI, PAYLOAD, CHECK, RUN_REL, RUN.
- IDLE:
  - 0xA5 or 0x5A: latch the target, clear the word address and checksum, go to CNT_LO.
  - 0xC3: go to RUN_REL.
  - Any other byte (including 0x3C): ignored, stay in IDLE.
- CNT_LO -> CNT_HI: on each accepted byte.
- CNT_HI:
  - CNT > DEPTH: set load_err, go to IDLE, no writes.
  - CNT == 0: go to CHECK.
  - Otherwise: go to PAYLOAD.
- PAYLOAD:
  - Bytes are assembled into a 32-bit shift register; each payload byte is XORed into the checksum.
  - On the 4th byte of a word, in the next cycle: target w_enb=1 for one cycle, w_byte_enb=4'hF, w_addr=word index, w_dat=assembled word.
  - The word index then increments. The non-target BRAM port stays idle.
  - After word CNT-1 is accepted, go to CHECK.
- CHECK: on the accepted byte, if CHK == running XOR then clear load_err, else set load_err. Go to IDLE in both cases. Words already written are not rolled back.
- Stall/reset release:
  - cpu_rst=1 and pc_stall=1 in every state except RUN_REL and RUN.
  - RUN_REL lasts exactly one cycle: cpu_rst=0, pc_stall=1.
  - RUN: cpu_rst=0, pc_stall=0.
- RUN: 0x3C returns to IDLE, re-asserting cpu_rst and pc_stall in the next cycle. All other bytes are ignored.
- Timing:
  - Write latency is 1 cycle from the accepted 4th byte to w_enb high.
  - Back-to-back words at 1 byte/cycle give w_enb high every 4th cycle.
- Address wrap: cannot occur, because CNT ≤ DEPTH is enforced. At CNT == DEPTH the final address is DEPTH-1.
- Reset mid-frame: the FSM returns to IDLE and any pending w_enb is dropped (0 in the cycle after rst). BRAM contents are untouched.
- in_valid low: no state change. Bytes may arrive with arbitrary gaps.

Decomposition:
- Shared package/include (rv32i_params.vh): the command codes LDR_CMD_IMEM/DMEM/RUN/HALT and the state encodings.
- Sub-module ldr_word_asm: byte-to-word shift register, byte counter (0-3), word-done strobe and running XOR.

Test Plan:
- IMEM load: 0xA5, 02, 00, 13 00 50 00, 93 02 A0 00, CHK=0x72 -> i_w_enb pulses twice with addr 0/1 and data 0x00500013/0x00A00293; load_err=0; d_w_enb never high.
- Bad checksum: data load of one word 0x00000008 with CHK=0x00 -> d_mem[0]=0x00000008 written, load_err=1. A following good frame clears it.
- Oversize count: 0x5A, CNT=0x1001 (DEPTH=4096) -> load_err=1, state IDLE, no write pulses.
- Run/halt: 0xC3 -> one cycle with cpu_rst=0/pc_stall=1, then 0/0. Then 0x3C -> next cycle 1/1. Garbage byte 0x77 in IDLE is ignored.
- Gapped stream: in_valid toggles every 3 cycles during a 3-word load -> identical BRAM writes, addr 0,1,2.
- Reset mid-payload: rst after 2 bytes of a word -> no w_enb, state IDLE, cpu_rst=1; a fresh frame then loads correctly.
